mem_store_queue: RTL and testbench
==================================

// Module: mem_store_queue
// PURPOSE
//  Parametrised store queue between AGU and dcache; successor to the fixed 2-commit store buffer. Holds stores from
//  enqueue until ROB commit, drains committed stores in order to the dcache, and gives same-cycle store-to-load
//  forwarding to the load queue. Adds configurable depth, commit width, io-store ordering and flush of speculative entries.
// PARAMETERS
//  DEPTH     8   entries; power of 2, >=2
//  COMMIT_W  2   max stores committed per cycle
//  ROB_W     5   ROB id width
// PORTS
//  cpu_clk_i         in   1        clock
//  cpu_rst_i         in   1        sync active-high reset
//  flush_i           in   1        discard all uncommitted entries
//  enq_en_i          in   1        enqueue store (from AGU)
//  enq_addr_i        in   30       word address
//  enq_data_i        in   32       store data
//  enq_bm_i          in   4        byte mask
//  enq_io_i          in   1        non-cacheable/io store
//  enq_rob_i         in   ROB_W    ROB id
//  enq_full_o        out  1        queue full; enqueue ignored while high
//  cmp_valid_o       out  1        store-complete pulse to ROB
//  cmp_rob_o         out  ROB_W    ROB id of completed store
//  commit_i          in   COMMIT_W commit strobes; popcount = stores retired this cycle
//  fwd_addr_i        in   30       load word address
//  fwd_bm_i          in   4        load byte mask
//  fwd_hit_o         out  1        some queued store overlaps the load
//  fwd_ok_o          out  1        youngest overlapping store fully covers load, not io
//  fwd_data_o        out  32       forwarded data
//  fwd_bm_o          out  4        byte mask of forwarding entry
//  st_valid_o        out  1        drain request to dcache
//  st_addr_o/data_o/bm_o/io_o out 30/32/4/1  drain payload
//  st_done_i         in   1        dcache accepted/finished drain
//  empty_o           out  1        no valid entries
// BEHAVIOUR
//  - Circular buffer; pointers head (drain), cmt (oldest uncommitted), tail; each $clog2(DEPTH)+1 bits, wrap via MSB.
//    Invariant head<=cmt<=tail (modular). full = tail-head==DEPTH; empty = tail==head.
//  - Reset: all pointers 0; cmp_valid_o=0, st_valid_o=0, enq_full_o=0, empty_o=1, fwd_* = 0. Reset mid-drain drops request.
//  - Enqueue: enq_en_i & !enq_full_o & !flush_i writes tail, tail++. cmp_valid_o/cmp_rob_o registered, 1 cycle later.
//    enq_en_i while full: dropped, no completion (AGU must stall on enq_full_o).
//  - Commit: cmt += popcount(commit_i). Strobes never exceed tail-cmt; simulation assertion otherwise.
//  - Flush: tail <= cmt after commit same cycle applied (commit first, then flush). Committed entries survive and drain.
//    Pending cmp_valid_o pulse for a flushed store is suppressed.
//  - Drain FSM: IDLE -> REQ when head!=cmt; st_valid_o=1, payload = entry[head], held stable until st_done_i.
//    st_done_i in REQ: head++, -> IDLE (1 idle cycle between drains). st_done_i outside REQ ignored. flush_i does not
//    affect REQ. io entry drains only when it is the only valid entry ahead of tail-flight (head==cmt-1 and no older
//    outstanding), guaranteeing strict io ordering.
//  - Forwarding (combinational, same cycle): scan valid entries head..tail-1, overlap = addr match & |(bm & fwd_bm_i).
//    Youngest overlapping selected. fwd_hit_o=any overlap; fwd_ok_o = hit & (ent_bm & fwd_bm_i)==fwd_bm_i & !ent_io.
//    fwd_data_o/fwd_bm_o from selected entry; 0 when no hit. Entry at head in REQ remains searchable until st_done_i.
//  - Same-cycle enqueue and forward query: new entry not visible until next cycle.
// CONFIGURATION
//  STQ_PERF_EN defined: adds outputs perf_full_stall_o[31:0] (cycles enq_en_i&enq_full_o) and perf_fwd_o[31:0]
//  (cycles fwd_ok_o); saturating, cleared on cpu_rst_i only. Undefined: ports and counters absent; no other change.
// STRUCTURE
//  Package mem_pkg: stq_entry_t {addr[29:0], data[31:0], bm[3:0], io}, drain state enum {STQ_IDLE, STQ_REQ}, STQ_ADDR_W.
//  One sub-module: stq_fwd_search (youngest-match priority search over entry array, given head/tail).
// TESTING
//  1. Enq A=0x100 D=0xAABBCCDD bm=F rob=3 -> next cycle cmp_valid_o=1 cmp_rob_o=3; st_valid_o stays 0 until commit_i=01.
//  2. Fill DEPTH=8 stores -> enq_full_o=1; 9th enq dropped, no completion; commit 2, drain 1 -> enq_full_o=0.
//  3. Enq 4 stores, commit_i=11 then flush_i -> entries 0,1 drain, tail==cmt, entries 2,3 never reach st_valid_o.
//  4. Two stores to 0x40 (bm=3 D=0x1111, then bm=F D=0x22223333); load 0x40 bm=C -> hit=1, ok=1, data=0x22223333.
//  5. Store 0x40 bm=3, load bm=F -> hit=1 ok=0; io store at 0x80 load bm=1 -> hit=1 ok=0.
//  6. Hold st_done_i low 5 cycles in REQ -> payload stable; pointer wrap after 20 enq/commit/drain, empty_o=1 at end.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the memory-side store queue.
package mem_pkg;

  localparam int unsigned STQ_ADDR_W = 30;
  localparam int unsigned STQ_DATA_W = 32;
  localparam int unsigned STQ_BM_W   = 4;

  // One buffered store as held in the queue and presented to the dcache.
  typedef struct packed {
    logic [STQ_ADDR_W-1:0] addr;
    logic [STQ_DATA_W-1:0] data;
    logic [STQ_BM_W-1:0]   bm;
    logic                  io;
  } stq_entry_t;

  // Drain FSM encoding.
  localparam logic [0:0] STQ_IDLE = 1'b0;
  localparam logic [0:0] STQ_REQ  = 1'b1;

endpackage

// File: rtl/stq_fwd_search.sv
// Youngest-match store-to-load forwarding search over the live window head..tail-1.
module stq_fwd_search
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PW    = $clog2(DEPTH) + 1
) (
  input  stq_entry_t             ents [DEPTH],
  input  logic [PW-1:0]          head,
  input  logic [PW-1:0]          tail,
  input  logic [STQ_ADDR_W-1:0]  addr,
  input  logic [STQ_BM_W-1:0]    bm,
  output logic                   hit,
  output logic                   ok,
  output logic [STQ_DATA_W-1:0]  data,
  output logic [STQ_BM_W-1:0]    ent_bm
);

  localparam int unsigned AW = PW - 1;

  logic [PW-1:0] cnt;
  logic [AW-1:0] idx;
  stq_entry_t    cur;
  stq_entry_t    sel;

  // Walk oldest to youngest so the last overlap found is the youngest one.
  always_comb begin
    cnt = tail - head;
    idx = '0;
    cur = '0;
    sel = '0;
    hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = head[AW-1:0] + AW'(i);
      cur = ents[idx];
      if ((PW'(i) < cnt) && (cur.addr == addr) && ((cur.bm & bm) != '0)) begin
        hit = 1'b1;
        sel = cur;
      end
    end
    ok     = hit & ((sel.bm & bm) == bm) & ~sel.io;
    data   = sel.data;
    ent_bm = sel.bm;
  end

endmodule

// File: rtl/mem_store_queue.sv
// Store queue between AGU and dcache: holds stores until ROB commit, drains
// committed stores in order, forwards to loads. Optional perf counters are
// built when STQ_PERF_EN is defined.
module mem_store_queue
  import mem_pkg::*;
#(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned COMMIT_W = 2,
  parameter int unsigned ROB_W    = 5
) (
  input  logic                   cpu_clk_i,
  input  logic                   cpu_rst_i,
  input  logic                   flush_i,
  input  logic                   enq_en_i,
  input  logic [STQ_ADDR_W-1:0]  enq_addr_i,
  input  logic [STQ_DATA_W-1:0]  enq_data_i,
  input  logic [STQ_BM_W-1:0]    enq_bm_i,
  input  logic                   enq_io_i,
  input  logic [ROB_W-1:0]       enq_rob_i,
  output logic                   enq_full_o,
  output logic                   cmp_valid_o,
  output logic [ROB_W-1:0]       cmp_rob_o,
  input  logic [COMMIT_W-1:0]    commit_i,
  input  logic [STQ_ADDR_W-1:0]  fwd_addr_i,
  input  logic [STQ_BM_W-1:0]    fwd_bm_i,
  output logic                   fwd_hit_o,
  output logic                   fwd_ok_o,
  output logic [STQ_DATA_W-1:0]  fwd_data_o,
  output logic [STQ_BM_W-1:0]    fwd_bm_o,
  output logic                   st_valid_o,
  output logic [STQ_ADDR_W-1:0]  st_addr_o,
  output logic [STQ_DATA_W-1:0]  st_data_o,
  output logic [STQ_BM_W-1:0]    st_bm_o,
  output logic                   st_io_o,
  input  logic                   st_done_i,
  output logic                   empty_o
`ifdef STQ_PERF_EN
  ,
  output logic [31:0]            perf_full_stall_o,
  output logic [31:0]            perf_fwd_o
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  stq_entry_t    ents [DEPTH];
  logic [PW-1:0] head_q, cmt_q, tail_q;
  logic [PW-1:0] head_nxt, cmt_nxt, tail_nxt;
  logic [PW-1:0] cmt_cnt;
  logic [PW-1:0] used;
  logic [PW-1:0] pend_ofs;
  logic          enq_fire;
  logic          drain_done;

  logic [0:0]    state_q, state_nxt;
  logic          load_req;
  stq_entry_t    head_ent;
  stq_entry_t    req_q;

  logic             cmp_q;
  logic [ROB_W-1:0] cmp_rob_q;
  logic [PW-1:0]    cmp_ptr_q;

  assign used       = tail_q - head_q;
  assign enq_full_o = (used == PW'(DEPTH));
  assign empty_o    = (tail_q == head_q);
  assign enq_fire   = enq_en_i & ~enq_full_o & ~flush_i;
  assign drain_done = (state_q == STQ_REQ) & st_done_i;
  assign head_ent   = ents[head_q[AW-1:0]];

  // Number of stores retired this cycle.
  always_comb begin
    cmt_cnt = '0;
    for (int unsigned i = 0; i < COMMIT_W; i++) begin
      cmt_cnt = cmt_cnt + PW'(commit_i[i]);
    end
  end

  // Pointer updates: commit is applied before flush trims tail back to cmt.
  always_comb begin
    cmt_nxt  = cmt_q + cmt_cnt;
    head_nxt = head_q + PW'(drain_done);
    tail_nxt = flush_i ? cmt_nxt : (tail_q + PW'(enq_fire));
  end

  // Pointer registers.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      head_q <= '0;
      cmt_q  <= '0;
      tail_q <= '0;
    end else begin
      head_q <= head_nxt;
      cmt_q  <= cmt_nxt;
      tail_q <= tail_nxt;
    end
  end

  // Entry storage; contents only matter inside the live window.
  always_ff @(posedge cpu_clk_i) begin
    if (enq_fire) begin
      ents[tail_q[AW-1:0]] <= '{addr: enq_addr_i, data: enq_data_i, bm: enq_bm_i, io: enq_io_i};
    end
  end

  // Completion pulse one cycle after enqueue; remembers which slot it belongs to.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      cmp_q     <= 1'b0;
      cmp_rob_q <= '0;
      cmp_ptr_q <= '0;
    end else begin
      cmp_q     <= enq_fire;
      cmp_rob_q <= enq_rob_i;
      cmp_ptr_q <= tail_q;
    end
  end

  // A pending completion is withheld if this cycle's flush discards its entry.
  assign pend_ofs    = cmp_ptr_q - head_q;
  assign cmp_valid_o = cmp_q & ~(flush_i & (pend_ofs >= (cmt_nxt - head_q)));
  assign cmp_rob_o   = cmp_rob_q;

  // Drain FSM next state. Single outstanding in-order drain keeps io stores
  // strictly ordered behind every older store.
  always_comb begin
    state_nxt = state_q;
    load_req  = 1'b0;
    case (state_q)
      STQ_IDLE: begin
        if (head_q != cmt_q) begin
          state_nxt = STQ_REQ;
          load_req  = 1'b1;
        end
      end
      STQ_REQ: begin
        if (st_done_i) state_nxt = STQ_IDLE;
      end
      default: state_nxt = STQ_IDLE;
    endcase
  end

  // Drain FSM state and latched payload held stable for the dcache.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      state_q <= STQ_IDLE;
      req_q   <= '0;
    end else begin
      state_q <= state_nxt;
      if (load_req) req_q <= head_ent;
    end
  end

  assign st_valid_o = (state_q == STQ_REQ);
  assign st_addr_o  = req_q.addr;
  assign st_data_o  = req_q.data;
  assign st_bm_o    = req_q.bm;
  assign st_io_o    = req_q.io;

  // Forwarding search over the current window; new enqueues appear next cycle.
  stq_fwd_search #(
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_fwd (
    .ents   (ents),
    .head   (head_q),
    .tail   (tail_q),
    .addr   (fwd_addr_i),
    .bm     (fwd_bm_i),
    .hit    (fwd_hit_o),
    .ok     (fwd_ok_o),
    .data   (fwd_data_o),
    .ent_bm (fwd_bm_o)
  );

  // ROB must never retire more stores than are waiting for commit.
  a_commit_bound: assert property (@(posedge cpu_clk_i) disable iff (cpu_rst_i)
    cmt_cnt <= (tail_q - cmt_q))
    else $error("mem_store_queue: commit exceeds uncommitted entries");

`ifdef STQ_PERF_EN
  // Saturating event counters, cleared only by reset.
  always_ff @(posedge cpu_clk_i) begin
    if (cpu_rst_i) begin
      perf_full_stall_o <= '0;
      perf_fwd_o        <= '0;
    end else begin
      if (enq_en_i && enq_full_o && (perf_full_stall_o != '1))
        perf_full_stall_o <= perf_full_stall_o + 32'd1;
      if (fwd_ok_o && (perf_fwd_o != '1))
        perf_fwd_o <= perf_fwd_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_store_queue.sv
// Scoreboard bench for mem_store_queue: completions and drains are predicted
// when stimulus is applied and consumed when the DUT produces them.
module tb_mem_store_queue;
  import mem_pkg::*;

  localparam int unsigned DEPTH    = 8;
  localparam int unsigned COMMIT_W = 2;
  localparam int unsigned ROB_W    = 5;

  logic                  cpu_clk_i = 1'b0;
  logic                  cpu_rst_i = 1'b1;
  logic                  flush_i = 1'b0;
  logic                  enq_en_i = 1'b0;
  logic [STQ_ADDR_W-1:0] enq_addr_i = '0;
  logic [STQ_DATA_W-1:0] enq_data_i = '0;
  logic [STQ_BM_W-1:0]   enq_bm_i = '0;
  logic                  enq_io_i = 1'b0;
  logic [ROB_W-1:0]      enq_rob_i = '0;
  logic                  enq_full_o;
  logic                  cmp_valid_o;
  logic [ROB_W-1:0]      cmp_rob_o;
  logic [COMMIT_W-1:0]   commit_i = '0;
  logic [STQ_ADDR_W-1:0] fwd_addr_i = '0;
  logic [STQ_BM_W-1:0]   fwd_bm_i = '0;
  logic                  fwd_hit_o;
  logic                  fwd_ok_o;
  logic [STQ_DATA_W-1:0] fwd_data_o;
  logic [STQ_BM_W-1:0]   fwd_bm_o;
  logic                  st_valid_o;
  logic [STQ_ADDR_W-1:0] st_addr_o;
  logic [STQ_DATA_W-1:0] st_data_o;
  logic [STQ_BM_W-1:0]   st_bm_o;
  logic                  st_io_o;
  logic                  st_done_i = 1'b0;
  logic                  empty_o;
`ifdef STQ_PERF_EN
  logic [31:0]           perf_full_stall_o;
  logic [31:0]           perf_fwd_o;
`endif

  mem_store_queue #(.DEPTH(DEPTH), .COMMIT_W(COMMIT_W), .ROB_W(ROB_W)) dut (
    .cpu_clk_i   (cpu_clk_i),
    .cpu_rst_i   (cpu_rst_i),
    .flush_i     (flush_i),
    .enq_en_i    (enq_en_i),
    .enq_addr_i  (enq_addr_i),
    .enq_data_i  (enq_data_i),
    .enq_bm_i    (enq_bm_i),
    .enq_io_i    (enq_io_i),
    .enq_rob_i   (enq_rob_i),
    .enq_full_o  (enq_full_o),
    .cmp_valid_o (cmp_valid_o),
    .cmp_rob_o   (cmp_rob_o),
    .commit_i    (commit_i),
    .fwd_addr_i  (fwd_addr_i),
    .fwd_bm_i    (fwd_bm_i),
    .fwd_hit_o   (fwd_hit_o),
    .fwd_ok_o    (fwd_ok_o),
    .fwd_data_o  (fwd_data_o),
    .fwd_bm_o    (fwd_bm_o),
    .st_valid_o  (st_valid_o),
    .st_addr_o   (st_addr_o),
    .st_data_o   (st_data_o),
    .st_bm_o     (st_bm_o),
    .st_io_o     (st_io_o),
    .st_done_i   (st_done_i),
    .empty_o     (empty_o)
`ifdef STQ_PERF_EN
    ,
    .perf_full_stall_o (perf_full_stall_o),
    .perf_fwd_o        (perf_fwd_o)
`endif
  );

  always #5 cpu_clk_i = ~cpu_clk_i;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference model state.
  stq_entry_t       uq[$];         // enqueued, not yet committed
  stq_entry_t       exp_drain[$];  // committed, awaiting drain
  logic [ROB_W-1:0] exp_cmp[$];    // completions awaiting cmp_valid_o
  bit               cmp_pend = 1'b0;
  int               probe_hit = -1;
  int unsigned      done_delay = 0;

  // One clock of stimulus; model is updated as the inputs are applied.
  task automatic cyc(input logic en, input logic [29:0] a, input logic [31:0] d,
                     input logic [3:0] b, input logic is_io, input logic [ROB_W-1:0] rob,
                     input logic [1:0] cm, input logic fl);
    int occ;
    int k;
    occ = uq.size() + exp_drain.size();
    check_eq("enq_full", enq_full_o, 64'(occ == DEPTH));
    check_eq("empty", empty_o, 64'(occ == 0));
    enq_en_i = en; enq_addr_i = a; enq_data_i = d; enq_bm_i = b;
    enq_io_i = is_io; enq_rob_i = rob; commit_i = cm; flush_i = fl;
    k = int'(cm[0]) + int'(cm[1]);
    if (cmp_pend && fl && (k < uq.size())) void'(exp_cmp.pop_back());
    for (int i = 0; i < k; i++) if (uq.size() > 0) exp_drain.push_back(uq.pop_front());
    if (fl) uq.delete();
    cmp_pend = 1'b0;
    if (en && !fl && (occ < DEPTH)) begin
      uq.push_back('{addr: a, data: d, bm: b, io: is_io});
      exp_cmp.push_back(rob);
      cmp_pend = 1'b1;
    end
    #1;
    if (probe_hit >= 0) check_eq("fwd_same_cycle", fwd_hit_o, 64'(probe_hit));
    @(posedge cpu_clk_i); #1;
    enq_en_i = 1'b0; commit_i = '0; flush_i = 1'b0;
  endtask

  task automatic enq(input logic [29:0] a, input logic [31:0] d, input logic [3:0] b,
                     input logic is_io, input logic [ROB_W-1:0] rob);
    cyc(1'b1, a, d, b, is_io, rob, 2'b00, 1'b0);
  endtask

  task automatic commit(input logic [1:0] cm);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, cm, 1'b0);
  endtask

  task automatic flush();
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 2'b00, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, '0, '0, 1'b0, '0, 2'b00, 1'b0);
  endtask

  // Bounded wait until at most 'left' committed stores remain undrained.
  task automatic wait_drain(input int left, input int max_cyc);
    for (int i = 0; i < max_cyc && exp_drain.size() > left; i++) idle(1);
    check_eq("drain_timeout", 64'(exp_drain.size() > left), 64'd0);
  endtask

  task automatic fwd_query(input string tag, input logic [29:0] a, input logic [3:0] b,
                           input logic hit, input logic ok, input logic [31:0] d,
                           input logic [3:0] ebm);
    fwd_addr_i = a; fwd_bm_i = b; #1;
    check_eq({tag, "_hit"}, fwd_hit_o, hit);
    check_eq({tag, "_ok"}, fwd_ok_o, ok);
    check_eq({tag, "_data"}, fwd_data_o, d);
    check_eq({tag, "_bm"}, fwd_bm_o, ebm);
  endtask

  // Completion monitor and dcache responder, both on the falling edge.
  stq_entry_t  held;
  int unsigned hold_cnt = 0;
  initial begin
    stq_entry_t cur;
    stq_entry_t e;
    forever begin
      @(negedge cpu_clk_i);
      st_done_i = 1'b0;
      if (!cpu_rst_i && cmp_valid_o) begin
        if (exp_cmp.size() == 0) check_eq("cmp_unexpected", 64'd1, 64'd0);
        else check_eq("cmp_rob", cmp_rob_o, exp_cmp.pop_front());
      end
      if (!cpu_rst_i && st_valid_o) begin
        cur = '{addr: st_addr_o, data: st_data_o, bm: st_bm_o, io: st_io_o};
        if (hold_cnt == 0) held = cur;
        else check_eq("st_stable", 64'(cur == held), 64'd1);
        if (hold_cnt < done_delay) hold_cnt++;
        else begin
          if (exp_drain.size() == 0) check_eq("st_unexpected", 64'd1, 64'd0);
          else begin
            e = exp_drain.pop_front();
            check_eq("st_addr_data", {cur.addr, cur.data}, {e.addr, e.data});
            check_eq("st_bm_io", {cur.bm, cur.io}, {e.bm, e.io});
          end
          st_done_i = 1'b1;
          hold_cnt  = 0;
        end
      end else begin
        hold_cnt = 0;
      end
    end
  end

  initial begin
    // Reset state.
    repeat (3) @(posedge cpu_clk_i);
    #1 cpu_rst_i = 1'b0;
    check_eq("rst_cmp_valid", cmp_valid_o, 0);
    check_eq("rst_st_valid", st_valid_o, 0);
    check_eq("rst_full", enq_full_o, 0);
    check_eq("rst_empty", empty_o, 1);
    fwd_query("rst_fwd", 30'h0, 4'h0, 0, 0, 32'h0, 4'h0);

    // Single store: completion next cycle, no drain before commit.
    enq(30'h100, 32'hAABBCCDD, 4'hF, 1'b0, 5'd3);
    check_eq("t1_cmp_valid", cmp_valid_o, 1);
    check_eq("t1_cmp_rob", cmp_rob_o, 5'd3);
    idle(3);
    check_eq("t1_no_drain", st_valid_o, 0);
    commit(2'b01);
    wait_drain(0, 10);
    idle(1);
    check_eq("t1_empty", empty_o, 1);

    // Fill to full; overflow enqueue dropped; one drain clears full.
    for (int i = 0; i < DEPTH; i++) enq(30'h200 + 30'(i), 32'h1000 + 32'(i), 4'hF, 1'b0, 5'(i));
    check_eq("t2_full", enq_full_o, 1);
    enq(30'h2FF, 32'hDEAD, 4'hF, 1'b0, 5'd31);
    commit(2'b11);
    wait_drain(1, 10);
    check_eq("t2_not_full", enq_full_o, 0);
    commit(2'b11); commit(2'b11); commit(2'b10); commit(2'b01);
    wait_drain(0, 60);
    idle(1);
    check_eq("t2_empty", empty_o, 1);

    // Commit two of four, then flush: only the committed pair drains.
    for (int i = 0; i < 4; i++) enq(30'h300 + 30'(i), 32'h3000 + 32'(i), 4'hF, 1'b0, 5'd10 + 5'(i));
    commit(2'b11);
    flush();
    wait_drain(0, 30);
    idle(8);
    check_eq("t3_empty", empty_o, 1);

    // Flush right after enqueue suppresses the completion; commit+flush keeps it.
    enq(30'h400, 32'h4444, 4'hF, 1'b0, 5'd20);
    flush();
    idle(2);
    check_eq("flush_empty", empty_o, 1);
    enq(30'h500, 32'h5050, 4'h3, 1'b0, 5'd21);
    cyc(1'b0, '0, '0, '0, 1'b0, '0, 2'b01, 1'b1);
    wait_drain(0, 10);

    // Youngest overlapping store forwards; same-cycle enqueue is invisible.
    enq(30'h40, 32'h00001111, 4'h3, 1'b0, 5'd1);
    enq(30'h40, 32'h22223333, 4'hF, 1'b0, 5'd2);
    fwd_query("t4_c", 30'h40, 4'hC, 1, 1, 32'h22223333, 4'hF);
    fwd_query("t4_3", 30'h40, 4'h3, 1, 1, 32'h22223333, 4'hF);
    fwd_query("t4_miss", 30'h48, 4'hF, 0, 0, 32'h0, 4'h0);
    fwd_addr_i = 30'h44; fwd_bm_i = 4'hF;
    probe_hit = 0;
    enq(30'h44, 32'h4400, 4'hF, 1'b0, 5'd7);
    probe_hit = -1;
    fwd_query("t4_next", 30'h44, 4'hF, 1, 1, 32'h4400, 4'hF);
    flush();
    fwd_query("t4_flushed", 30'h40, 4'hF, 0, 0, 32'h0, 4'h0);

    // Partial coverage and io stores are hits that cannot forward.
    enq(30'h40, 32'h5555, 4'h3, 1'b0, 5'd4);
    fwd_query("t5_partial", 30'h40, 4'hF, 1, 0, 32'h5555, 4'h3);
    enq(30'h80, 32'h77, 4'hF, 1'b1, 5'd5);
    fwd_query("t5_io", 30'h80, 4'h1, 1, 0, 32'h77, 4'hF);
    commit(2'b11);
    wait_drain(0, 20);
    idle(1);
    check_eq("t5_empty", empty_o, 1);

    // Stalled dcache: payload held, head entry still forwards.
    done_delay = 5;
    enq(30'h600, 32'hDEADBEEF, 4'hF, 1'b0, 5'd6);
    commit(2'b01);
    idle(3);
    check_eq("t6_st_valid", st_valid_o, 1);
    fwd_query("t6_head", 30'h600, 4'hF, 1, 1, 32'hDEADBEEF, 4'hF);
    wait_drain(0, 30);
    done_delay = 0;
    idle(1);
    fwd_query("t6_gone", 30'h600, 4'hF, 0, 0, 32'h0, 4'h0);

    // Pointer wrap with random data and alternating commit lanes.
    for (int i = 0; i < 20; i++) begin
      enq(30'h700 + 30'(i), $urandom, 4'($urandom_range(1, 15)), 1'b0, 5'(i));
      commit((i % 2 == 0) ? 2'b01 : 2'b10);
      idle(1);
    end
    wait_drain(0, 100);
    idle(2);
    check_eq("t6_wrap_empty", empty_o, 1);
    check_eq("end_cmp_left", 64'(exp_cmp.size()), 0);
    check_eq("end_uq_left", 64'(uq.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
